// File: rtl/dmem_responder.sv
// Data-memory responder: services one load/store per request after LATENCY busy
// cycles, stalling the core until a single-cycle ready (and optional err) pulse.
module dmem_responder #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_enable,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              ready,
   output logic              err
);

   localparam int          CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic              is_write;
      logic [ADDR_W-1:0] index;
      logic [DATA_W-1:0] data;
   } req_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   req_t              req_q;
   logic              err_pend;
   logic              req_present, req_valid, addr_ok;
   logic              accept, access;
   logic [DATA_W-1:0] mem [DEPTH];

   // Strobes are active low; exactly one select low plus an aligned in-range address is valid.
   assign req_present = ~mem_enable & (~mem_read | ~mem_write);
   assign addr_ok     = (addr[1:0] == 2'b00) && ({1'b0, addr} < BYTE_LIMIT);
   assign req_valid   = req_present & (mem_read ^ mem_write) & addr_ok;

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      accept    = 1'b0;
      access    = 1'b0;
      case (state)
         IDLE: begin
            if (req_present) begin
               stall = 1'b1;
               if (req_valid) begin
                  accept    = 1'b1;
                  state_nxt = BUSY;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt == '0) begin
               access    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign ready = (state == DONE);
   assign err   = ready & err_pend;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         err_pend <= 1'b0;
         req_q    <= '0;
         rdata    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            req_q.is_write <= ~mem_write;
            req_q.index    <= addr[ADDR_W+1:2];
            req_q.data     <= wdata;
            cnt            <= CNT_W'(LATENCY - 1);
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (state == IDLE && req_present)
            err_pend <= ~req_valid;
         if (access && !req_q.is_write)
            rdata <= mem[req_q.index];
      end
   end

   // Storage is never reset, but a write landing on a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && access && req_q.is_write)
         mem[req_q.index] <= req_q.data;
   end

endmodule
